// File: rtl/jtframe_debug_sched_if.sv
// Bus between core probe points / video timing and the debug scheduler.
//   master : drives lvbl, keys, auto_en, probe data/valid; reads the view
//   slave  : the scheduler; reads inputs, drives debug_view, view_sel, vb_start
interface jtframe_debug_sched_if #(
  parameter int NSRC = 4
);
  localparam int SELW = $clog2(NSRC);

  logic                 lvbl;        // vertical blank, active low
  logic                 page_next;   // key level
  logic                 page_prev;   // key level
  logic                 auto_en;     // 1 = round-robin
  logic [NSRC*8-1:0]    src_data;    // source i = src_data[8*i+:8]
  logic [NSRC-1:0]      src_valid;
  logic [7:0]           debug_view;  // snapshot of selected source
  logic [SELW-1:0]      view_sel;    // index shown in debug_view
  logic                 vb_start;    // 1-cycle pulse at vblank start

  modport master (
    output lvbl, page_next, page_prev, auto_en, src_data, src_valid,
    input  debug_view, view_sel, vb_start
  );

  modport slave (
    input  lvbl, page_next, page_prev, auto_en, src_data, src_valid,
    output debug_view, view_sel, vb_start
  );
endinterface

// File: rtl/jtframe_debug_sched.sv
// Debug overlay scheduler: shares one 8-bit debug_view among NSRC probes.
// Selection is manual (next/prev key edges) or automatic round-robin,
// advancing every HOLD_FRAMES frames and fast-skipping invalid sources.
// The view is snapshotted only at vblank start so it never tears.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   freeze     : (only with JTFRAME_DEBUG_FREEZE_EN) holds snapshot and
//                frame counter while high; keys still move the selection
//   bus        : jtframe_debug_sched_if.slave (lvbl, keys, auto_en,
//                src_data, src_valid -> debug_view, view_sel, vb_start)
//
// Optional feature macro: JTFRAME_DEBUG_FREEZE_EN
module jtframe_debug_sched #(
  parameter  int NSRC        = 4,
  parameter  int HOLD_FRAMES = 60,
  localparam int SELW        = $clog2(NSRC)
) (
  input  logic clk,
  input  logic rst_n,
`ifdef JTFRAME_DEBUG_FREEZE_EN
  input  logic freeze,
`endif
  jtframe_debug_sched_if.slave bus
);

  typedef enum logic { MANUAL, AUTO } state_t;

  state_t               state, state_nx;
  logic [SELW-1:0]      sel, sel_nx, key_sel;
  logic [7:0]           fcnt, fcnt_nx;
  logic                 last_next, last_prev, last_lvbl;
  logic                 armed;
  logic                 nxt, prv, vbs, vbs_eff, hold;
  logic [NSRC-1:0][7:0] src_arr;

  assign src_arr = bus.src_data;

`ifdef JTFRAME_DEBUG_FREEZE_EN
  assign hold = freeze;
`else
  assign hold = 1'b0;
`endif

  function automatic logic [SELW-1:0] inc(input logic [SELW-1:0] s);
    return (s == SELW'(NSRC-1)) ? '0 : s + 1'b1;
  endfunction

  function automatic logic [SELW-1:0] dec(input logic [SELW-1:0] s);
    return (s == '0) ? SELW'(NSRC-1) : s - 1'b1;
  endfunction

  // last_next/last_prev come out of reset at 0, so a key held across reset
  // release would look like a fresh press. 'armed' masks key edges for the
  // first cycle after reset, letting last_* catch up with the held level.
  assign nxt     = armed & bus.page_next & ~last_next;
  assign prv     = armed & bus.page_prev & ~last_prev;
  assign vbs     = ~bus.lvbl & last_lvbl;
  assign vbs_eff = vbs & ~hold;

  always_comb begin
    key_sel = sel;
    if (nxt && !prv) key_sel = inc(sel);
    if (prv && !nxt) key_sel = dec(sel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MANUAL;
      sel       <= '0;
      fcnt      <= '0;
      last_next <= 1'b0;
      last_prev <= 1'b0;
      last_lvbl <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nx;
      sel       <= sel_nx;
      fcnt      <= fcnt_nx;
      last_next <= bus.page_next;
      last_prev <= bus.page_prev;
      last_lvbl <= bus.lvbl;
      armed     <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    fcnt_nx  = fcnt;
    case (state)
      MANUAL: begin
        sel_nx  = key_sel;
        fcnt_nx = '0;
        if (bus.auto_en) state_nx = AUTO;
      end
      AUTO: begin
        if (!bus.auto_en) begin
          state_nx = MANUAL;
          fcnt_nx  = '0;
        end else if (nxt || prv) begin
          // a key restarts the hold period even if next+prev cancel out
          sel_nx  = key_sel;
          fcnt_nx = '0;
        end else if (vbs_eff) begin
          if (!bus.src_valid[sel]) begin
            sel_nx  = inc(sel);
            fcnt_nx = '0;
          end else if (fcnt == 8'(HOLD_FRAMES-1)) begin
            sel_nx  = inc(sel);
            fcnt_nx = '0;
          end else begin
            fcnt_nx = fcnt + 8'd1;
          end
        end
      end
      default: state_nx = MANUAL;
    endcase
  end

  // Snapshot uses the sel of the vblank cycle itself, so any selection
  // change made on that cycle shows up one frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.debug_view <= 8'h00;
      bus.view_sel   <= '0;
      bus.vb_start   <= 1'b0;
    end else begin
      bus.vb_start <= vbs;
      if (vbs_eff) begin
        bus.debug_view <= bus.src_valid[sel] ? src_arr[sel] : 8'h00;
        bus.view_sel   <= sel;
      end
    end
  end

endmodule
